// File: rtl/aes128_cbc_decrypt.sv
// Iterative AES-128 decryptor. It restarts on any input change and, when AES_CBC_CHAIN_EN is defined, XORs in the IV (CBC).
// Without AES_CBC_CHAIN_EN it decrypts in ECB mode and ignores iv.
module aes128_cbc_decrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    output logic [127:0] plaintext,
    output logic         valid
);

    typedef enum logic [1:0] {IDLE, KEXP, LOAD, ROUND} state_t;

    state_t       state, state_d;
    logic [127:0] ct_q, key_q, st, rk;
    logic [3:0]   cnt;
    logic         primed, capture, iv_diff;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte n of the state (n = 4*col + row) lives at bits [127-8n -: 8].
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

`ifdef AES_CBC_CHAIN_EN
    logic [127:0] iv_q;
    assign iv_diff = (iv != iv_q);
`else
    logic unused_iv;
    assign unused_iv = ^iv;
    assign iv_diff   = 1'b0;
`endif

    assign capture = !primed || (ciphertext != ct_q) || (key != key_q) || iv_diff;

    // One SubWord serves both directions: forward uses w3, reverse uses the recovered w3 of rk_{i-1}.
    logic [31:0]  w0, w1, w2, w3, w3p, sub_src, t;
    logic [127:0] rk_fwd, rk_rev, isb, rnd_res, rnd_out, pt_next;

    always_comb begin
        {w0, w1, w2, w3} = rk;
        w3p     = w3 ^ w2;
        sub_src = (state == ROUND) ? w3p : w3;
        t       = sub_word({sub_src[23:0], sub_src[31:24]}) ^ {rcon(cnt), 24'h0};
        rk_fwd[127:96] = w0 ^ t;
        rk_fwd[95:64]  = w1 ^ rk_fwd[127:96];
        rk_fwd[63:32]  = w2 ^ rk_fwd[95:64];
        rk_fwd[31:0]   = w3 ^ rk_fwd[63:32];
        rk_rev  = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3p};
        isb     = inv_shift_sub(st);
        rnd_res = isb ^ rk_rev;
        rnd_out = inv_mix_columns(rnd_res);
`ifdef AES_CBC_CHAIN_EN
        pt_next = rnd_res ^ iv_q;
`else
        pt_next = rnd_res;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = IDLE;
            KEXP:    if (cnt == 4'd10) state_d = LOAD;
            LOAD:    state_d = ROUND;
            ROUND:   if (cnt == 4'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (capture) state_d = KEXP;
    end

    // In ROUND, cnt is the round-key index i being undone; the round applied is i-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ct_q      <= '0;
            key_q     <= '0;
`ifdef AES_CBC_CHAIN_EN
            iv_q      <= '0;
`endif
            primed    <= 1'b0;
            st        <= '0;
            rk        <= '0;
            cnt       <= 4'd0;
            plaintext <= '0;
            valid     <= 1'b0;
        end else if (capture) begin
            ct_q   <= ciphertext;
            key_q  <= key;
`ifdef AES_CBC_CHAIN_EN
            iv_q   <= iv;
`endif
            primed <= 1'b1;
            valid  <= 1'b0;
            rk     <= key;
            cnt    <= 4'd1;
        end else begin
            case (state)
                KEXP: begin
                    rk  <= rk_fwd;
                    cnt <= cnt + 4'd1;
                end
                LOAD: begin
                    st  <= ct_q ^ rk;
                    cnt <= 4'd10;
                end
                ROUND: begin
                    rk  <= rk_rev;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        plaintext <= pt_next;
                        valid     <= 1'b1;
                    end else begin
                        st <= rnd_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_cbc_decrypt.sv
// Directed bench for aes128_cbc_decrypt using FIPS-197 and SP800-38A vectors; honours AES_CBC_CHAIN_EN.
module tb_aes128_cbc_decrypt;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] ciphertext = '0;
    logic [127:0] key = '0;
    logic [127:0] iv = '0;
    logic [127:0] plaintext;
    logic         valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];
    logic [127:0] sp_ct[4], sp_iv[4], sp_pt[4];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] ONES   = {128{1'b1}};

    aes128_cbc_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .ciphertext (ciphertext),
        .key        (key),
        .iv         (iv),
        .plaintext  (plaintext),
        .valid      (valid)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // checks
    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic apply(input logic [127:0] c, input logic [127:0] k, input logic [127:0] v);
        @(negedge clk);
        ciphertext = c;
        key        = k;
        iv         = v;
    endtask

    // Next posedge is the capture edge; measures edges to valid and checks the held output.
    task automatic wait_result(input string tag);
        logic [127:0] held, exp;
        int           n;
        int           disturbed;
        @(posedge clk);
        @(negedge clk);
        held      = plaintext;
        disturbed = valid ? 1 : 0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid) break;
            if (plaintext !== held) disturbed = 1;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check_int({tag, " latency"}, n, 21);
        check_int({tag, " held"}, disturbed, 0);
        check128({tag, " plaintext"}, plaintext, exp);
    endtask

    task automatic check_stable(input string tag, input logic [127:0] exp);
        int dropped;
        dropped = 0;
        repeat (25) begin
            @(negedge clk);
            if (!valid) dropped = 1;
        end
        check_int({tag, " valid_drop"}, dropped, 0);
        check128({tag, " plaintext"}, plaintext, exp);
    endtask

    initial begin
`ifdef AES_CBC_CHAIN_EN
        sp_ct[0] = 128'h7649abac8119b246cee98e9b12e9197d;
        sp_ct[1] = 128'h5086cb9b507219ee95db113a917678b2;
        sp_ct[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
        sp_ct[3] = 128'h3ff1caa1681fac09120eca307586e1a7;
`else
        sp_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        sp_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        sp_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        sp_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
`endif
        sp_iv[0] = 128'h000102030405060708090a0b0c0d0e0f;
        sp_iv[1] = 128'h7649abac8119b246cee98e9b12e9197d;
        sp_iv[2] = 128'h5086cb9b507219ee95db113a917678b2;
        sp_iv[3] = 128'h73bed6b8e3c1743b7116e69e22229516;
        sp_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        sp_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        sp_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        sp_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;

        // reset state, then first edge after release captures without any input change
        ciphertext = CT_C1;
        key        = KEY_C1;
        iv         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check128("reset plaintext", plaintext, '0);
        check_int("reset valid", int'(valid), 0);
        rst = 1'b1;
        exp_q.push_back(PT_C1);
        wait_result("fips_c1");

        // all-ones IV
`ifdef AES_CBC_CHAIN_EN
        apply(CT_C1, KEY_C1, ONES);
        exp_q.push_back(128'hffeeddccbbaa99887766554433221100);
        wait_result("c1_iv_ones");
`else
        apply(CT_C1, KEY_C1, ONES);
        check_stable("c1_iv_ignored", PT_C1);
`endif

        // input glitch that reverts before any edge must not retrigger
        @(negedge clk);
        ciphertext = ~CT_C1;
        #2;
        ciphertext = CT_C1;
        check_stable("glitch_revert", plaintext === 'x ? '0 : PT_C1
`ifdef AES_CBC_CHAIN_EN
            ^ ONES
`endif
        );

        // FIPS-197 appendix B
        apply(CT_B, KEY_B, '0);
        exp_q.push_back(PT_B);
        wait_result("fips_b");

        // ciphertext change sampled at edge 10 restarts the operation
        apply(CT_C1, KEY_B, '0);
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check_int("restart mid valid", int'(valid), 0);
        ciphertext = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        exp_q.push_back(128'h6bc1bee22e409f96e93d7e117393172a);
        wait_result("restart");

        // asynchronous reset during ROUND
        apply(sp_ct[3], KEY_B, sp_iv[3]);
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check128("midround reset plaintext", plaintext, '0);
        check_int("midround reset valid", int'(valid), 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(sp_pt[3]);
        wait_result("after_reset");

        // SP800-38A chained blocks
        for (int i = 0; i < 3; i++) begin
            apply(sp_ct[i], KEY_B, sp_iv[i]);
            exp_q.push_back(sp_pt[i]);
            wait_result($sformatf("sp800_blk%0d", i + 1));
        end

        check_int("scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
